// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one ALU between two requesters with round-robin arbitration.
//   One transaction is in flight at a time: grant (IDLE) -> wait ALU_LAT
//   cycles (EXEC) -> hold response until the consumer takes it (RESP).
//   A saturating counter tracks accepted responses carrying the ERR flag.
//
// Ports
//   i_clk, i_rst            clock (rising edge), synchronous active-high reset
//   i_reqN_valid/o_reqN_ready, i_reqN_arg0/arg1/oper   requester N (N = 0, 1)
//   o_alu_arg0/arg1/oper    registered operands/opcode driven to the ALU
//   i_alu_result/i_alu_flag ALU outputs (flag: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVF)
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_id/result/flag    owning requester and captured ALU outputs
//   o_busy                  high whenever a transaction is in progress
//   o_err_cnt               saturating count of accepted ERR responses
module alu_req_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LEN     = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_arg0,
    input  logic [WIDTH-1:0] i_req0_arg1,
    input  logic [LEN-1:0]   i_req0_oper,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_arg0,
    input  logic [WIDTH-1:0] i_req1_arg1,
    input  logic [LEN-1:0]   i_req1_oper,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [LEN-1:0]   o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [3:0]       i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_flag,
    output logic             o_busy,
    output logic [7:0]       o_err_cnt
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [2:0] LatCnt = 3'(ALU_LAT);

    state_e     state_q, state_d;
    logic       rr_q;
    logic [2:0] cnt_q;
    logic       grant_id;
    logic       req_hs;
    logic       lat_done;

    // Round-robin pointer only matters on contention; a lone request wins outright.
    always_comb begin
        grant_id = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = rr_q;
        end
    end

    assign o_req0_ready = (state_q == StIdle) && i_req0_valid && !grant_id;
    assign o_req1_ready = (state_q == StIdle) && i_req1_valid && grant_id;
    assign req_hs       = o_req0_ready || o_req1_ready;
    assign lat_done     = (cnt_q == LatCnt);
    assign o_busy       = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_hs)      state_d = StExec;
            StExec:  if (lat_done)    state_d = StResp;
            StResp:  if (i_rsp_ready) state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
            o_alu_arg0   <= '0;
            o_alu_arg1   <= '0;
            o_alu_oper   <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_flag   <= '0;
            o_err_cnt    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req_hs) begin
                        o_alu_arg0 <= grant_id ? i_req1_arg0 : i_req0_arg0;
                        o_alu_arg1 <= grant_id ? i_req1_arg1 : i_req0_arg1;
                        o_alu_oper <= grant_id ? i_req1_oper : i_req0_oper;
                        o_rsp_id   <= grant_id;
                        rr_q       <= ~grant_id;
                        cnt_q      <= '0;
                    end
                end
                StExec: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (lat_done) begin
                        o_rsp_result <= i_alu_result;
                        o_rsp_flag   <= i_alu_flag;
                        o_rsp_valid  <= 1'b1;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        if (o_rsp_flag[0] && (o_err_cnt != 8'hFF)) begin
                            o_err_cnt <= o_err_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one ALU_LAT=1 instance driven by a
// stub ALU, plus an ALU_LAT=0 instance for the short-latency case.
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_arg0, req0_arg1, req1_arg0, req1_arg1;
    logic [1:0] req0_oper, req1_oper;
    logic [3:0] alu_arg0, alu_arg1, alu_result, alu_flag;
    logic [1:0] alu_oper;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0] rsp_result, rsp_flag;
    logic [7:0] err_cnt;

    logic       force_en;
    logic [3:0] force_flag;

    // ALU_LAT=0 instance signals
    logic       z_req0_valid, z_req0_ready, z_req1_valid, z_req1_ready;
    logic [3:0] z_req1_arg0, z_req1_arg1;
    logic [1:0] z_req1_oper;
    logic [3:0] z_alu_arg0, z_alu_arg1, z_alu_result, z_alu_flag;
    logic [1:0] z_alu_oper;
    logic       z_rsp_valid, z_rsp_id, z_busy;
    logic [3:0] z_rsp_result, z_rsp_flag;
    logic [7:0] z_err_cnt;

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] alu_res(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a - b;
            2'b01:   return ~(a & b);
            2'b10:   return a + b;
            default: return a ^ b;
        endcase
    endfunction

    // {OVF, POS, NEG, ERR}
    function automatic logic [3:0] alu_flg(input logic [3:0] r);
        return {1'b0, (!r[3] && (r != 4'd0)), r[3], 1'b0};
    endfunction

    assign alu_result   = alu_res(alu_arg0, alu_arg1, alu_oper);
    assign alu_flag     = force_en ? force_flag : alu_flg(alu_result);
    assign z_alu_result = alu_res(z_alu_arg0, z_alu_arg1, z_alu_oper);
    assign z_alu_flag   = alu_flg(z_alu_result);

    alu_req_arbiter #(.WIDTH(4), .LEN(2), .ALU_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_arg0(req0_arg0), .i_req0_arg1(req0_arg1), .i_req0_oper(req0_oper),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_arg0(req1_arg0), .i_req1_arg1(req1_arg1), .i_req1_oper(req1_oper),
        .o_alu_arg0(alu_arg0), .o_alu_arg1(alu_arg1), .o_alu_oper(alu_oper),
        .i_alu_result(alu_result), .i_alu_flag(alu_flag),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag),
        .o_busy(busy), .o_err_cnt(err_cnt)
    );

    alu_req_arbiter #(.WIDTH(4), .LEN(2), .ALU_LAT(0)) dut_z (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(z_req0_valid), .o_req0_ready(z_req0_ready),
        .i_req0_arg0(4'd0), .i_req0_arg1(4'd0), .i_req0_oper(2'd0),
        .i_req1_valid(z_req1_valid), .o_req1_ready(z_req1_ready),
        .i_req1_arg0(z_req1_arg0), .i_req1_arg1(z_req1_arg1), .i_req1_oper(z_req1_oper),
        .o_alu_arg0(z_alu_arg0), .o_alu_arg1(z_alu_arg1), .o_alu_oper(z_alu_oper),
        .i_alu_result(z_alu_result), .i_alu_flag(z_alu_flag),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(1'b1), .o_rsp_id(z_rsp_id),
        .o_rsp_result(z_rsp_result), .o_rsp_flag(z_rsp_flag),
        .o_busy(z_busy), .o_err_cnt(z_err_cnt)
    );

    // Inputs change at posedge+2; checks happen at posedge+3.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction on the ALU_LAT=1 instance with i_rsp_ready held high.
    // lat is the cycle (relative to the grant cycle) where o_rsp_valid is seen.
    task automatic run_txn(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, output logic [3:0] res,
                           output logic [3:0] flg, output logic rid, output int lat);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_arg0 = a; req1_arg1 = b; req1_oper = op;
        end else begin
            req0_valid = 1'b1; req0_arg0 = a; req0_arg1 = b; req0_oper = op;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick(); #1; n++;
        end
        chk("txn_grant", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick(); #1; lat++;
        end
        chk("txn_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        res = rsp_result;
        flg = rsp_flag;
        rid = rsp_id;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] res, flg;
        logic       rid;
        int         lat;
        int         n;

        rst = 1'b1; rsp_ready = 1'b1; force_en = 1'b0; force_flag = 4'd0;
        req0_valid = 0; req0_arg0 = 0; req0_arg1 = 0; req0_oper = 0;
        req1_valid = 0; req1_arg0 = 0; req1_arg1 = 0; req1_oper = 0;
        z_req0_valid = 0; z_req1_valid = 0;
        z_req1_arg0 = 0; z_req1_arg1 = 0; z_req1_oper = 0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu", {22'd0, alu_arg0, alu_arg1, alu_oper}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_rsp", {23'd0, rsp_id, rsp_result, rsp_flag}, 32'd0);
        tick();

        // Single request: 5 - 3 on requester 0
        req0_valid = 1'b1; req0_arg0 = 4'b0101; req0_arg1 = 4'b0011; req0_oper = 2'b00;
        #1;
        chk("s_ready0_T", {31'd0, req0_ready}, 32'd1);
        chk("s_ready1_T", {31'd0, req1_ready}, 32'd0);
        tick(); req0_valid = 1'b0; #1;
        chk("s_alu_T1", {22'd0, alu_arg0, alu_arg1, alu_oper}, {22'd0, 4'b0101, 4'b0011, 2'b00});
        chk("s_busy_T1", {31'd0, busy}, 32'd1);
        chk("s_rsp_valid_T1", {31'd0, rsp_valid}, 32'd0);
        tick(); #1;
        chk("s_rsp_valid_T2", {31'd0, rsp_valid}, 32'd0);
        tick(); #1;
        chk("s_rsp_valid_T3", {31'd0, rsp_valid}, 32'd1);
        chk("s_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("s_rsp_result", {28'd0, rsp_result}, 32'h2);
        chk("s_rsp_flag", {28'd0, rsp_flag}, 32'h4);
        tick(); #1;
        chk("s_rsp_valid_T4", {31'd0, rsp_valid}, 32'd0);
        chk("s_busy_T4", {31'd0, busy}, 32'd0);

        // Contention from reset: order 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_arg0 = 4'd7; req0_arg1 = 4'd2; req0_oper = 2'b00;
        req1_valid = 1'b1; req1_arg0 = 4'd3; req1_arg1 = 4'd4; req1_oper = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                tick(); #1; n++;
            end
            chk("c_grant0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("c_grant1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick(); #1;
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick(); #1; n++;
            end
            chk("c_rsp_id", {31'd0, rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("c_rsp_result", {28'd0, rsp_result}, (k % 2 == 1) ? 32'd7 : 32'd5);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure: 9 + 3 from requester 1, consumer stalls
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_arg0 = 4'b1001; req1_arg1 = 4'b0011; req1_oper = 2'b10;
        #1;
        chk("b_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_arg0 = 4'b0110; req0_arg1 = 4'b0001; req0_oper = 2'b00;
        #1;
        chk("b_ready0_exec", {31'd0, req0_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick(); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("b_rsp", {23'd0, rsp_id, rsp_result, rsp_flag}, {23'd0, 1'b1, 4'b1100, 4'b0010});
            chk("b_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
            chk("b_busy", {31'd0, busy}, 32'd1);
            tick(); #1;
        end
        rsp_ready = 1'b1;
        tick(); #1;
        chk("b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("b_next_grant", {31'd0, req0_ready}, 32'd1);
        chk("b_result_retained", {28'd0, rsp_result}, 32'hC);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("b_alu_next", {22'd0, alu_arg0, alu_arg1, alu_oper}, {22'd0, 4'b0110, 4'b0001, 2'b00});
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick(); #1; n++;
        end
        chk("b_next_result", {28'd0, rsp_result}, 32'h5);
        tick();

        // Error counting with saturation
        force_en = 1'b1; force_flag = 4'b0001;
        for (int i = 1; i <= 260; i++) begin
            run_txn(1'b0, 4'd1, 4'd1, 2'b00, res, flg, rid, lat);
            if (i == 1 || i == 100 || i == 255 || i == 260) begin
                chk("e_err_cnt", {24'd0, err_cnt}, (i > 255) ? 32'd255 : i);
            end
        end
        force_flag = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, 4'd2, 4'd1, 2'b00, res, flg, rid, lat);
        end
        chk("e_err_hold", {24'd0, err_cnt}, 32'd255);
        chk("e_last_flag", {28'd0, flg}, 32'h4);
        chk("e_last_lat", lat, 32'd3);
        force_en = 1'b0;

        // Reset during EXEC
        req0_valid = 1'b1; req0_arg0 = 4'd9; req0_arg1 = 4'd4; req0_oper = 2'b10;
        #1;
        chk("r_grant", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("r_in_exec", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(); #1;
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("r_alu", {22'd0, alu_arg0, alu_arg1, alu_oper}, 32'd0);
        chk("r_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("r_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("r_rr_grant0", {31'd0, req0_ready}, 32'd1);
        chk("r_rr_grant1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // ALU_LAT=0 instance: nand on requester 1
        z_req1_valid = 1'b1; z_req1_arg0 = 4'b1111; z_req1_arg1 = 4'b0000; z_req1_oper = 2'b01;
        #1;
        chk("z_ready1_T", {31'd0, z_req1_ready}, 32'd1);
        tick();
        z_req1_valid = 1'b0;
        #1;
        chk("z_rsp_valid_T1", {31'd0, z_rsp_valid}, 32'd0);
        tick(); #1;
        chk("z_rsp_valid_T2", {31'd0, z_rsp_valid}, 32'd1);
        chk("z_rsp_id", {31'd0, z_rsp_id}, 32'd1);
        chk("z_rsp_result", {28'd0, z_rsp_result}, 32'hF);
        tick(); #1;
        chk("z_idle", {31'd0, z_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
